// File: rtl/name_scroller_if.sv
// name_scroller_if
//   Control, message-write and display bundle for the name scroller.
//   master : the controller side (drives start/stop/pause and message writes,
//            observes status and the four digit codes).
//   slave  : the scroller itself.
//   Signals:
//     start, stop, pause   scrolling control levels
//     wr_en, wr_addr, wr_code
//                          message store write port
//     busy, step, pos      status: running/holding, advance pulse, window position
//     d3..d0               character codes for HEX3..HEX0 (d3 leftmost)
interface name_scroller_if #(
  parameter int AW = 3
);
  logic          start;
  logic          stop;
  logic          pause;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_code;
  logic          busy;
  logic          step;
  logic [AW-1:0] pos;
  logic [3:0]    d3;
  logic [3:0]    d2;
  logic [3:0]    d1;
  logic [3:0]    d0;

  modport master (
    output start, stop, pause, wr_en, wr_addr, wr_code,
    input  busy, step, pos, d3, d2, d1, d0
  );

  modport slave (
    input  start, stop, pause, wr_en, wr_addr, wr_code,
    output busy, step, pos, d3, d2, d1, d0
  );
endinterface

// File: rtl/name_scroller.sv
// name_scroller
//   Scrolls a writable message of LEN 4-bit character codes through a
//   4-character window feeding four HEX 7-segment name decoders. The window
//   advances one position every DIV clocks while running; start/stop/pause
//   control the scroll (priority stop > start > pause).
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   name_scroller_if.slave: control inputs, message write port,
//           busy/step/pos status and the d3..d0 window codes
//   Configuration macro NAME_SCROLL_BOUNCE_EN: when defined the window
//   bounces between position 0 and LEN-4 instead of wrapping around.
module name_scroller #(
  parameter int         LEN        = 8,
  parameter int         AW         = 3,
  parameter int         DIV        = 25_000_000,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic             clk,
  input logic             rst,
  name_scroller_if.slave  bus
);

  localparam int            PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC   = PW'(DIV - 1);
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [AW-1:0] pos_reg, pos_next;
  logic [AW-1:0] pos_adv;
  logic          step_c;

  // Storage covers the full address space; entries at or beyond LEN are
  // never written and stay blank, so every window index is in range.
  logic [3:0]    msg_reg [2**AW];
  logic [3:0]    win_next [4];
  logic [3:0]    win_reg [4];

`ifdef NAME_SCROLL_BOUNCE_EN
  localparam logic [AW-1:0] TOP = AW'(LEN - 4);
  localparam logic DIR_FWD  = 1'b0;
  localparam logic DIR_BACK = 1'b1;
  logic dir_reg, dir_next, dir_adv;

  // Bounce: the direction flips on the step that lands on either end.
  always_comb begin
    pos_adv = pos_reg;
    dir_adv = dir_reg;
    if (LEN == 4) begin
      pos_adv = '0;
    end else if (dir_reg == DIR_FWD) begin
      pos_adv = pos_reg + AW'(1);
      if (pos_adv == TOP) dir_adv = DIR_BACK;
    end else begin
      pos_adv = pos_reg - AW'(1);
      if (pos_adv == '0) dir_adv = DIR_FWD;
    end
  end
`else
  always_comb begin
    pos_adv = (pos_reg == LAST) ? '0 : pos_reg + AW'(1);
  end
`endif

  // Next-state logic; stop beats start beats pause in every state.
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    pos_next   = pos_reg;
    step_c     = 1'b0;
`ifdef NAME_SCROLL_BOUNCE_EN
    dir_next   = dir_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_RUN;
          presc_next = '0;
          pos_next   = '0;
`ifdef NAME_SCROLL_BOUNCE_EN
          dir_next   = DIR_FWD;
`endif
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
        end else if (bus.start) begin
          presc_next = '0;
          pos_next   = '0;
`ifdef NAME_SCROLL_BOUNCE_EN
          dir_next   = DIR_FWD;
`endif
        end else if (bus.pause) begin
          // Count is frozen, including at terminal count.
          state_next = ST_HOLD;
        end else if (presc_reg == TC) begin
          presc_next = '0;
          pos_next   = pos_adv;
          step_c     = 1'b1;
`ifdef NAME_SCROLL_BOUNCE_EN
          dir_next   = dir_adv;
`endif
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
        end else if (bus.start) begin
          state_next = ST_RUN;
          presc_next = '0;
          pos_next   = '0;
`ifdef NAME_SCROLL_BOUNCE_EN
          dir_next   = DIR_FWD;
`endif
        end else if (!bus.pause) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      pos_reg   <= '0;
`ifdef NAME_SCROLL_BOUNCE_EN
      dir_reg   <= DIR_FWD;
`endif
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      pos_reg   <= pos_next;
`ifdef NAME_SCROLL_BOUNCE_EN
      dir_reg   <= dir_next;
`endif
    end
  end

  // Message store, writable in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) msg_reg[i] <= BLANK_CODE;
    end else if (bus.wr_en && (int'(bus.wr_addr) < LEN)) begin
      msg_reg[bus.wr_addr] <= bus.wr_code;
    end
  end

  // Window digit gi shows the character at offset 3-gi from pos
  // (digit 3 is leftmost and shows msg[pos]).
  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    logic [AW:0]   raw;
    logic [AW-1:0] idx;
    assign raw = {1'b0, pos_reg} + (AW+1)'(3 - gi);
`ifdef NAME_SCROLL_BOUNCE_EN
    // pos never exceeds LEN-4, so no wrap is needed.
    assign idx = raw[AW-1:0];
`else
    assign idx = (raw >= (AW+1)'(LEN)) ? AW'(raw - (AW+1)'(LEN)) : raw[AW-1:0];
`endif
    assign win_next[gi] = (state_reg == ST_IDLE) ? BLANK_CODE : msg_reg[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) win_reg[i] <= BLANK_CODE;
    end else begin
      for (int i = 0; i < 4; i++) win_reg[i] <= win_next[i];
    end
  end

  assign bus.busy = (state_reg != ST_IDLE);
  assign bus.step = step_c;
  assign bus.pos  = pos_reg;
  assign bus.d3   = win_reg[3];
  assign bus.d2   = win_reg[2];
  assign bus.d1   = win_reg[1];
  assign bus.d0   = win_reg[0];

endmodule
